// File: rtl/regwrite_tracer.sv
// regwrite_tracer: snoops the register-file write port and logs value changes on watched registers into a FIFO
// Ports:
//   clk, reset (sync, active-low)
//   en                          tracing enable
//   rf_we, rf_waddr, rf_wdata   register-file write port being snooped
//   out_valid/out_ready         head-of-FIFO handshake
//   out_cycle/out_addr/out_old/out_new  head entry fields, 0 while empty
//   count, overflow, dropped    occupancy and overflow accounting
module regwrite_tracer #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter logic [2**ADDR_W-1:0] WATCH_MASK = 32'h0003_0100,
   parameter int DEPTH = 8,
   parameter int CNT_W = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     en,
   input  logic                     rf_we,
   input  logic [ADDR_W-1:0]        rf_waddr,
   input  logic [DATA_W-1:0]        rf_wdata,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [CNT_W-1:0]         out_cycle,
   output logic [ADDR_W-1:0]        out_addr,
   output logic [DATA_W-1:0]        out_old,
   output logic [DATA_W-1:0]        out_new,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow,
   output logic [CNT_W-1:0]         dropped
);
   localparam int PW = $clog2(DEPTH);
   localparam int NREG = 2**ADDR_W;
   typedef struct packed {
      logic [CNT_W-1:0]  cyc;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] old_v;
      logic [DATA_W-1:0] new_v;
   } entry_t;
   logic [CNT_W-1:0] cyc;
   logic [DATA_W-1:0] shadow [NREG];
   entry_t mem [DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [DATA_W-1:0] cur;
   logic log_hit, full, pop, push, drop;
   entry_t head;
   assign out_valid = count != '0;
   assign out_cycle = head.cyc;
   assign out_addr = head.addr;
   assign out_old = head.old_v;
   assign out_new = head.new_v;
   // cur is the pre-update shadow, so a same-cycle shadow write still logs the old value
   always_comb begin
      cur = shadow[rf_waddr];
      log_hit = rf_we && en && WATCH_MASK[rf_waddr] && rf_waddr != '0 && rf_wdata != cur;
      full = count == (PW+1)'(DEPTH);
      pop = out_valid && out_ready;
      push = log_hit && (!full || pop);
      drop = log_hit && full && !pop;
      head = out_valid ? mem[rd_ptr] : '0;
   end
   always_ff @(posedge clk) begin
      if (!reset) begin
         cyc <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count <= '0;
         overflow <= 1'b0;
         dropped <= '0;
         for (int i = 0; i < NREG; i++) shadow[i] <= '0;
      end else begin
         cyc <= cyc + 1'b1;
         if (rf_we && rf_waddr != '0) shadow[rf_waddr] <= rf_wdata;
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         count <= count + (PW+1)'(push) - (PW+1)'(pop);
         if (drop) overflow <= 1'b1;
         if (drop && dropped != '1) dropped <= dropped + 1'b1;
      end
   end
   // storage needs no reset: pointers and count define which slots are live
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {cyc, rf_waddr, cur, rf_wdata};
   end
endmodule

// File: tb/tb_regwrite_tracer.sv
// tb_regwrite_tracer: directed and random checks of regwrite_tracer against a queue-based model
module tb_regwrite_tracer;
   localparam int DEPTH = 8;
   localparam logic [31:0] MASK = 32'h0003_0100;
   logic clk = 0, reset = 0, en = 0, rf_we = 0, out_ready = 0;
   logic [4:0] rf_waddr = '0;
   logic [31:0] rf_wdata = '0;
   logic out_valid, overflow;
   logic [15:0] out_cycle, dropped;
   logic [4:0] out_addr;
   logic [31:0] out_old, out_new;
   logic [3:0] count;
   int checks = 0, failures = 0;
   typedef struct {
      logic [15:0] cyc;
      logic [4:0]  addr;
      logic [31:0] o;
      logic [31:0] n;
   } ent_t;
   ent_t q[$];
   logic [31:0] msh [32];
   logic [15:0] mcyc, mdrop;
   logic mover;

   regwrite_tracer dut (
      .clk(clk), .reset(reset), .en(en), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .out_valid(out_valid), .out_ready(out_ready), .out_cycle(out_cycle), .out_addr(out_addr),
      .out_old(out_old), .out_new(out_new), .count(count), .overflow(overflow), .dropped(dropped)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // what the tracer must do at the coming edge, given the inputs now applied
   task automatic model();
      ent_t e;
      if (!reset) begin
         q.delete();
         foreach (msh[i]) msh[i] = '0;
         mcyc = '0;
         mdrop = '0;
         mover = 0;
      end else begin
         if (q.size() > 0 && out_ready) void'(q.pop_front());
         if (rf_we && en && MASK[rf_waddr] && rf_waddr != 0 && rf_wdata != msh[rf_waddr]) begin
            e.cyc = mcyc; e.addr = rf_waddr; e.o = msh[rf_waddr]; e.n = rf_wdata;
            if (q.size() < DEPTH) q.push_back(e);
            else begin
               mover = 1;
               if (mdrop != 16'hffff) mdrop++;
            end
         end
         if (rf_we && rf_waddr != 0) msh[rf_waddr] = rf_wdata;
         mcyc++;
      end
   endtask

   task automatic tick();
      model();
      @(posedge clk);
      #1;
      chk("valid", out_valid, q.size() != 0);
      chk("count", count, q.size());
      chk("overflow", overflow, mover);
      chk("dropped", dropped, mdrop);
      chk("cycle", out_cycle, q.size() ? q[0].cyc : 16'h0);
      chk("addr", out_addr, q.size() ? q[0].addr : 5'h0);
      chk("old", out_old, q.size() ? q[0].o : 32'h0);
      chk("new", out_new, q.size() ? q[0].n : 32'h0);
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      rf_we = 1; rf_waddr = a; rf_wdata = d;
      tick();
      rf_we = 0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic do_reset();
      reset = 0;
      tick();
      reset = 1;
   endtask

   initial begin
      // 1: single logged change at counter 3
      do_reset();
      en = 1; out_ready = 1;
      idle(3);
      wr(8, 32'h5);
      chk("t1_cycle", out_cycle, 3);
      chk("t1_addr", out_addr, 8);
      chk("t1_old", out_old, 0);
      chk("t1_new", out_new, 5);
      idle(1);
      chk("t1_empty", count, 0);
      // 2: identical, unwatched and r0 writes are not logged
      do_reset();
      wr(8, 5); wr(8, 5); wr(9, 7); wr(0, 1);
      idle(1);
      chk("t2_empty", out_valid, 0);
      wr(9, 8);
      // 3: overflow on the ninth write while stalled
      do_reset();
      out_ready = 0;
      for (int v = 1; v <= 9; v++) wr(16, v);
      chk("t3_count", count, 8);
      chk("t3_ovf", overflow, 1);
      chk("t3_drop", dropped, 1);
      chk("t3_head", out_new, 1);
      // 4: push and pop together while full
      out_ready = 1;
      wr(17, 32'h55);
      chk("t4_count", count, 8);
      chk("t4_drop", dropped, 1);
      for (int v = 2; v <= 8; v++) begin
         chk("t3_drain_new", out_new, v);
         chk("t3_drain_old", out_old, v - 1);
         tick();
      end
      chk("t4_last_addr", out_addr, 17);
      chk("t4_last_new", out_new, 32'h55);
      idle(1);
      chk("t4_empty", count, 0);
      // 5: disabled writes still update the shadow
      do_reset();
      en = 0;
      wr(8, 32'h10);
      en = 1;
      wr(8, 32'h20);
      chk("t5_old", out_old, 32'h10);
      chk("t5_new", out_new, 32'h20);
      idle(1);
      // 6: reset mid-drain
      do_reset();
      out_ready = 0;
      wr(8, 1); wr(8, 2); wr(8, 3);
      out_ready = 1; tick();
      out_ready = 0; tick();
      out_ready = 1; reset = 0; tick();
      chk("t6_valid", out_valid, 0);
      chk("t6_count", count, 0);
      chk("t6_ovf", overflow, 0);
      reset = 1;
      wr(8, 1);
      chk("t6_cycle", out_cycle, 0);
      chk("t6_old", out_old, 0);
      chk("t6_new", out_new, 1);
      // random traffic
      for (int k = 0; k < 800; k++) begin
         logic [4:0] alist [6];
         alist = '{5'd0, 5'd8, 5'd9, 5'd16, 5'd17, 5'(k)};
         reset = $urandom_range(0, 79) != 0;
         en = $urandom_range(0, 5) != 0;
         rf_we = $urandom_range(0, 2) != 0;
         rf_waddr = alist[$urandom_range(0, 5)];
         rf_wdata = $urandom_range(0, 3);
         out_ready = $urandom_range(0, 3) == 0;
         tick();
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/regwrite_tracer.md
Name: regwrite_tracer

Overview:
- Synthesizable register-write change tracer for the MIPS single-cycle core.
- Sits beside the register file and snoops its write port.
- Logs every value change on a parametrised set of watched registers into a FIFO. Each entry holds a cycle stamp, the register address, the old value and the new value.
- Generalises single-register ($t0) change monitoring to any register mask, with buffering, a drain handshake and overflow accounting.

Parameters:
- DATA_W, 32, register data width
- ADDR_W, 5, register address width (2**ADDR_W registers)
- WATCH_MASK, 32'h0003_0100, bit i set = register i watched (default r8, r16, r17)
- DEPTH, 8, FIFO entries; power of two, >= 2
- CNT_W, 16, cycle stamp width

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-low reset (asserted when 0)
- en  in  1  1 = tracing enabled; 0 = no new entries are logged
- rf_we  in  1  register-file write enable, same cycle as the write commit
- rf_waddr  in  ADDR_W  register-file write address
- rf_wdata  in  DATA_W  register-file write data
- out_valid  out  1  FIFO head entry valid
- out_ready  in  1  consumer accepts the head entry
- out_cycle  out  CNT_W  head entry cycle stamp
- out_addr  out  ADDR_W  head entry register address
- out_old  out  DATA_W  head entry previous value
- out_new  out  DATA_W  head entry new value
- count  out  $clog2(DEPTH)+1  entries currently held
- overflow  out  1  sticky flag; set when an entry was dropped
- dropped  out  CNT_W  number of dropped entries, saturating

Behaviour:

Reset (reset==0 at a rising edge):
- Cycle counter = 0.
- All shadow registers = 0, matching the register-file reset contents.
- FIFO emptied: out_valid=0, count=0.
- overflow=0, dropped=0.
- out_cycle, out_addr, out_old and out_new drive 0 while the FIFO is empty.
- Reset wins over every simultaneous event, including a mid-drain handshake.

Cycle counter:
- Holds 0 in the first cycle after reset deasserts.
- Increments by 1 every cycle, regardless of en.
- Wraps modulo 2**CNT_W.

Shadow registers:
- One per register address.
- shadow[a] <= rf_wdata whenever rf_we=1, a=rf_waddr and a!=0. This holds regardless of en or the mask, so shadows always mirror the register file.
- Writes to address 0 are ignored entirely.

Log condition, evaluated in a cycle:
- rf_we=1, en=1, WATCH_MASK[rf_waddr]=1, rf_waddr!=0, and rf_wdata != shadow[rf_waddr].
- A write of an identical value is not logged.

Entry contents:
- {cycle counter value in the write cycle, rf_waddr, shadow[rf_waddr] before the update, rf_wdata}.

FIFO:
- Registered, no bypass: an entry pushed at edge N shows on out_valid in the cycle after edge N, i.e. 1-cycle latency.
- The head fields are stable while out_valid=1 and out_ready=0.
- Pop happens when out_valid && out_ready at a rising edge.
- Push and pop in the same cycle:
  - count unchanged.
  - Allowed when full: the pop frees the slot and the push is accepted.
  - Allowed when empty only as push alone (no pop possible).

Overflow:
- A push while full with no simultaneous pop drops the new entry. Existing entries are untouched.
- overflow is set to 1 and stays set until reset.
- dropped increments and saturates at 2**CNT_W-1.

Pointers:
- Read and write pointers wrap modulo DEPTH.
- count spans 0..DEPTH inclusive.

Simultaneous events:
- A single write port means at most one candidate entry per cycle.
- A shadow update and its logging use the pre-update shadow value in the same cycle.

Test Plan:
1. Release reset; at counter=3 write r8=0x0000_0005; out_ready=1 -> one entry {cycle=3, addr=8, old=0, new=5}, out_valid high for 1 cycle, count returns to 0.
2. Write r8=5 twice, then r9=7 (unwatched), then r0=1 -> exactly one entry {addr=8, old=0, new=5}; shadow[9]=7 afterwards, proven by a later write to r9 after adding bit 9 to WATCH_MASK in a second build.
3. out_ready=0; DEPTH=8; nine changing writes to r16 (values 1..9) -> count=8, overflow=1, dropped=1; drain yields new values 1..8 in order, with old = previous value.
4. FIFO full; the same cycle has a changing write to r17 and out_ready=1 -> count stays 8, no drop, overflow unchanged, r17 entry appears last.
5. en=0 while writing r8=0x10, then en=1 and write r8=0x20 -> a single entry {old=0x10, new=0x20}.
6. FIFO holding 3 entries with out_ready toggling; assert reset for one edge mid-drain -> next cycle: out_valid=0, count=0, overflow=0, dropped=0, counter=0, and a following write r8=1 logs old=0.
